// File: rtl/fir_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared fixed-point types, default tap count and the
//                sequencer state encoding for the fir_mac_seq front-end.
//  Revision    : 1.0  initial release
// ============================================================================
package fir_pkg;

    localparam int NTAPS_DEFAULT = 64;
    localparam int SAMPLE_W      = 16;

    typedef logic signed [SAMPLE_W-1:0] q15_t;
    typedef logic signed [SAMPLE_W-1:0] q7_9_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_MAC     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUT     = 3'd4
    } fir_state_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_delay_line.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module      : fir_delay_line
//  Description : NTAPS-deep circular sample history with a write pointer and a
//                combinational tap read k positions behind the newest sample.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEFAULT,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic [AW-1:0]       tap_k,
    output logic [SAMPLE_W-1:0] tap_data
);

    q15_t          r_mem [NTAPS];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] w_newest;
    logic [AW-1:0] w_rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[r_wr_ptr] <= q15_t'(wr_data);
            r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
    end

    // Pointer arithmetic wraps naturally in AW bits, giving modulo-NTAPS indexing.
    assign w_newest  = r_wr_ptr - 1'b1;
    assign w_rd_addr = w_newest - tap_k;
    assign tap_data  = r_mem[w_rd_addr];

endmodule : fir_delay_line
`default_nettype wire

// File: rtl/fir_mac_seq.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module      : fir_mac_seq
//  Description : Sample front-end and sequencer for the fir_alu MAC datapath:
//                one accumulator clear plus NTAPS MACs per accepted sample,
//                result captured and offered on a valid/ready stream.
//                Optional saturation counter: FIR_MAC_SEQ_SAT_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEFAULT,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic                clk,
    input  logic                rst,
    // sample input stream
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    // coefficient write port
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic [SAMPLE_W-1:0] coef_wdata,
    output logic                coef_err,
    // fir_alu interface
    output logic                alu_clr_acc,
    output logic                alu_en_mac,
    output logic [SAMPLE_W-1:0] alu_a_q15,
    output logic [SAMPLE_W-1:0] alu_b_q15,
    input  logic [SAMPLE_W-1:0] alu_y_q7_9,
    input  logic                alu_y_saturated,
    // result output stream
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SAMPLE_W-1:0] m_data,
    output logic                m_sat,
    output logic [15:0]         sat_count
);

    fir_state_t          r_state;
    fir_state_t          w_state_next;
    logic [AW-1:0]       r_k;
    q15_t                r_coef [NTAPS];
    logic                r_coef_err;
    logic                r_m_valid;
    q7_9_t               r_m_data;
    logic                r_m_sat;
    logic                w_idle;
    logic                w_accept;
    logic                w_last_tap;
    logic                w_out_hs;
    logic [SAMPLE_W-1:0] w_tap_data;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle && s_valid;
    assign w_last_tap = (r_k == AW'(NTAPS - 1));
    assign w_out_hs   = r_m_valid && m_ready;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (s_valid) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_state_next = ST_MAC;
            end
            ST_MAC: begin
                if (w_last_tap) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_state_next = ST_OUT;
            end
            ST_OUT: begin
                if (w_out_hs) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_ready     = 1'b0;
        alu_clr_acc = 1'b0;
        alu_en_mac  = 1'b0;
        alu_a_q15   = '0;
        alu_b_q15   = '0;
        case (r_state)
            ST_IDLE: begin
                s_ready = 1'b1;
            end
            ST_CLEAR: begin
                alu_clr_acc = 1'b1;
            end
            ST_MAC: begin
                alu_en_mac = 1'b1;
                alu_a_q15  = w_tap_data;
                alu_b_q15  = r_coef[r_k];
            end
            default: begin
                s_ready = 1'b0;
            end
        endcase
    end

    // Tap counter restarts in CLEAR and wraps back to zero after the last MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_k <= '0;
        end else if (r_state == ST_MAC) begin
            r_k <= r_k + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sample history
    // ------------------------------------------------------------------
    fir_delay_line #(
        .NTAPS (NTAPS),
        .AW    (AW)
    ) u_dline (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_accept),
        .wr_data  (s_data),
        .tap_k    (r_k),
        .tap_data (w_tap_data)
    );

    // ------------------------------------------------------------------
    // Coefficient register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (coef_we && w_idle) begin
            r_coef[coef_addr] <= q15_t'(coef_wdata);
        end
    end

    // A write outside IDLE would corrupt a pass in flight, so it is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coef_err <= 1'b0;
        end else begin
            r_coef_err <= coef_we && !w_idle;
        end
    end

    assign coef_err = r_coef_err;

    // ------------------------------------------------------------------
    // Result capture and output stream
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sat   <= 1'b0;
        end else if (r_state == ST_CAPTURE) begin
            r_m_valid <= 1'b1;
            r_m_data  <= q7_9_t'(alu_y_q7_9);
            r_m_sat   <= alu_y_saturated;
        end else if (w_out_hs) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_sat   = r_m_sat;

`ifdef FIR_MAC_SEQ_SAT_CNT_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (w_out_hs && r_m_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`else
    assign sat_count = '0;
`endif

endmodule : fir_mac_seq
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module      : tb_fir_mac_seq
//  Description : Self-checking bench for fir_mac_seq with a behavioural
//                fir_alu stand-in and a shift-register FIR reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_mac_seq;
    import fir_pkg::*;

    localparam int NT  = 64;
    localparam int AW  = $clog2(NT);
`ifdef FIR_MAC_SEQ_SAT_CNT_EN
    localparam bit SATCNT_EN = 1'b1;
`else
    localparam bit SATCNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        coef_err;
    logic        alu_clr_acc;
    logic        alu_en_mac;
    logic [15:0] alu_a_q15;
    logic [15:0] alu_b_q15;
    logic [15:0] alu_y_q7_9;
    logic        alu_y_saturated;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_sat;
    logic [15:0] sat_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_seq #(.NTAPS(NT), .AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_wdata      (coef_wdata),
        .coef_err        (coef_err),
        .alu_clr_acc     (alu_clr_acc),
        .alu_en_mac      (alu_en_mac),
        .alu_a_q15       (alu_a_q15),
        .alu_b_q15       (alu_b_q15),
        .alu_y_q7_9      (alu_y_q7_9),
        .alu_y_saturated (alu_y_saturated),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_sat           (m_sat),
        .sat_count       (sat_count)
    );

    // Q2.30 sum -> Q7.9 with round-half-up and saturation; returns {sat, value}.
    function automatic logic [16:0] rnd_sat(input longint acc);
        longint r;
        logic [15:0] v;
        r = (acc + 64'sd1048576) >>> 21;
        if (r > 32767) return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        v = r[15:0];
        return {1'b0, v};
    endfunction

    // fir_alu stand-in
    longint alu_acc = 0;
    always @(posedge clk) begin
        if (alu_clr_acc) alu_acc <= 0;
        else if (alu_en_mac)
            alu_acc <= alu_acc + longint'($signed(alu_a_q15)) * longint'($signed(alu_b_q15));
    end
    always_comb {alu_y_saturated, alu_y_q7_9} = rnd_sat(alu_acc);

    // Reference model: history as a shift array, newest sample at index 0.
    int          hist  [NT];
    int          mcoef [NT];
    logic [15:0] exp_data;
    logic        exp_sat;
    int          exp_satcnt;

    task automatic model_clear();
        for (int i = 0; i < NT; i++) begin
            hist[i]  = 0;
            mcoef[i] = 0;
        end
        exp_satcnt = 0;
    endtask

    task automatic model_accept(input logic [15:0] x, input bit we, input int addr, input logic [15:0] wd);
        longint sum;
        if (we) mcoef[addr] = int'($signed(wd));
        for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'($signed(x));
        sum = 0;
        for (int i = 0; i < NT; i++) sum += longint'(hist[i]) * longint'(mcoef[i]);
        {exp_sat, exp_data} = rnd_sat(sum);
    endtask

    task automatic model_handshake();
        if (SATCNT_EN && exp_sat && exp_satcnt < 65535) exp_satcnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; coef_we = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int addr, input logic [15:0] wd);
        coef_we = 1'b1; coef_addr = AW'(addr); coef_wdata = wd;
        @(negedge clk);
        coef_we = 1'b0;
        mcoef[addr] = int'($signed(wd));
    endtask

    task automatic load_coefs(input logic [15:0] v, input bit rnd);
        for (int i = 0; i < NT; i++) write_coef(i, rnd ? 16'($urandom) : v);
        n_checks++;
        if (coef_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_coef_err: got %b expected 0", coef_err);
        end
    endtask

    task automatic accept_sample(input logic [15:0] x, input bit we, input int addr, input logic [15:0] wd);
        int guard = 0;
        while (s_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (s_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: s_ready got %b expected 1", s_ready);
            return;
        end
        s_valid = 1'b1; s_data = x;
        coef_we = we; coef_addr = AW'(addr); coef_wdata = wd;
        @(posedge clk);
        #1 accept_cyc = cyc;
        model_accept(x, we, addr, wd);
        @(negedge clk);
        s_valid = 1'b0; coef_we = 1'b0; s_data = '0;
        n_checks++;
        if (alu_clr_acc !== 1'b1 || s_ready !== 1'b0 || alu_en_mac !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_cycle: clr=%b ready=%b en=%b expected 1 0 0", alu_clr_acc, s_ready, alu_en_mac);
        end
    endtask

    task automatic finish_result(input int delay, output logic [15:0] d, output logic s);
        int guard = 0;
        d = 'x; s = 'x;
        while (m_valid !== 1'b1 && guard < NT + 20) begin
            @(negedge clk);
            guard++;
        end
        if (m_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL result_timeout: m_valid got %b expected 1", m_valid);
            return;
        end
        n_checks++;
        if (cyc - accept_cyc != NT + 2) begin
            n_fail++;
            $display("FAIL latency: got %0d edges expected %0d", cyc - accept_cyc, NT + 2);
        end
        n_checks++;
        if (m_data !== exp_data) begin
            n_fail++;
            $display("FAIL m_data: got %h expected %h", m_data, exp_data);
        end
        n_checks++;
        if (m_sat !== exp_sat) begin
            n_fail++;
            $display("FAIL m_sat: got %b expected %b", m_sat, exp_sat);
        end
        d = m_data; s = m_sat;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== d || m_sat !== s || s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: valid=%b data=%h sat=%b ready=%b expected 1 %h %b 0",
                         m_valid, m_data, m_sat, s_ready, d, s);
            end
        end
        m_ready = 1'b1;
        @(posedge clk);
        model_handshake();
        @(negedge clk);
        m_ready = 1'b0;
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake: valid=%b ready=%b expected 0 1", m_valid, s_ready);
        end
        n_checks++;
        if (sat_count !== 16'(exp_satcnt)) begin
            n_fail++;
            $display("FAIL sat_count: got %0d expected %0d", sat_count, exp_satcnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'h0 || m_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stream: ready=%b valid=%b data=%h sat=%b expected 1 0 0000 0",
                     s_ready, m_valid, m_data, m_sat);
        end
        n_checks++;
        if (alu_clr_acc !== 1'b0 || alu_en_mac !== 1'b0 || alu_a_q15 !== 16'h0 || alu_b_q15 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_alu: clr=%b en=%b a=%h b=%h expected all 0",
                     alu_clr_acc, alu_en_mac, alu_a_q15, alu_b_q15);
        end
        n_checks++;
        if (coef_err !== 1'b0 || sat_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_misc: coef_err=%b sat_count=%h expected 0 0000", coef_err, sat_count);
        end
    endtask

    task automatic test_impulse();
        logic [15:0] d;
        logic s;
        logic [15:0] want;
        load_coefs(16'h4000, 1'b0);
        for (int n = 0; n <= NT; n++) begin
            accept_sample(n == 0 ? 16'h4000 : 16'h0000, 1'b0, 0, 16'h0);
            finish_result(0, d, s);
            want = (n < NT) ? 16'h0080 : 16'h0000;
            n_checks++;
            if (d !== want || s !== 1'b0) begin
                n_fail++;
                $display("FAIL impulse[%0d]: got %h/%b expected %h/0", n, d, s, want);
            end
        end
    endtask

    task automatic test_step();
        logic [15:0] d;
        logic s;
        int prev_cyc;
        int want;
        do_reset();
        load_coefs(16'h4000, 1'b0);
        prev_cyc = 0;
        for (int n = 0; n < NT + 2; n++) begin
            accept_sample(16'h4000, 1'b0, 0, 16'h0);
            if (n > 0) begin
                n_checks++;
                if (accept_cyc - prev_cyc != NT + 4) begin
                    n_fail++;
                    $display("FAIL period: got %0d expected %0d", accept_cyc - prev_cyc, NT + 4);
                end
            end
            prev_cyc = accept_cyc;
            finish_result(0, d, s);
            want = (n < NT) ? 128 * (n + 1) : 8192;
            n_checks++;
            if (d !== 16'(want)) begin
                n_fail++;
                $display("FAIL step[%0d]: got %0d expected %0d", n, d, want);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        logic s;
        do_reset();
        load_coefs(16'h8000, 1'b0);
        for (int n = 0; n < NT + 2; n++) begin
            accept_sample(16'h8000, 1'b0, 0, 16'h0);
            finish_result(0, d, s);
            if (n == 62) begin
                n_checks++;
                if (d !== 16'd32256 || s !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat62: got %0d/%b expected 32256/0", d, s);
                end
            end
            if (n >= 63) begin
                n_checks++;
                if (d !== 16'h7FFF || s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat%0d: got %h/%b expected 7fff/1", n, d, s);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        logic s;
        logic [15:0] x2;
        int guard = 0;
        accept_sample(16'($urandom), 1'b0, 0, 16'h0);
        while (m_valid !== 1'b1 && guard < NT + 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== exp_data || m_sat !== exp_sat) begin
            n_fail++;
            $display("FAIL bp_first: valid=%b data=%h sat=%b expected 1 %h %b", m_valid, m_data, m_sat, exp_data, exp_sat);
        end
        d = m_data; s = m_sat;
        x2 = 16'($urandom);
        s_valid = 1'b1; s_data = x2;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== d || m_sat !== s || s_ready !== 1'b0 || alu_clr_acc !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: valid=%b data=%h sat=%b ready=%b clr=%b expected 1 %h %b 0 0",
                         m_valid, m_data, m_sat, s_ready, alu_clr_acc, d, s);
            end
        end
        m_ready = 1'b1;
        @(posedge clk);
        model_handshake();
        @(negedge clk);
        m_ready = 1'b0;
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b expected 0 1", m_valid, s_ready);
        end
        @(posedge clk);
        #1 accept_cyc = cyc;
        model_accept(x2, 1'b0, 0, 16'h0);
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++;
        if (s_ready !== 1'b0 || alu_clr_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: ready=%b clr=%b expected 0 1", s_ready, alu_clr_acc);
        end
        finish_result(3, d, s);
    endtask

    task automatic test_busy_write();
        logic [15:0] d;
        logic s;
        do_reset();
        load_coefs(16'h4000, 1'b0);
        accept_sample(16'h7FFF, 1'b0, 0, 16'h0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (alu_en_mac !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_mac: en=%b expected 1", alu_en_mac);
        end
        coef_we = 1'b1; coef_addr = AW'(3); coef_wdata = 16'h0000;
        @(negedge clk);
        coef_we = 1'b0;
        n_checks++;
        if (coef_err !== 1'b1) begin
            n_fail++;
            $display("FAIL coef_err_pulse: got %b expected 1", coef_err);
        end
        @(negedge clk);
        n_checks++;
        if (coef_err !== 1'b0) begin
            n_fail++;
            $display("FAIL coef_err_width: got %b expected 0", coef_err);
        end
        finish_result(0, d, s);
        for (int n = 1; n <= 3; n++) begin
            accept_sample(16'h0000, 1'b0, 0, 16'h0);
            finish_result(0, d, s);
        end
        n_checks++;
        if (d !== 16'd256) begin
            n_fail++;
            $display("FAIL busy_coef_kept: got %0d expected 256", d);
        end
    endtask

    task automatic test_midpass_reset();
        int guard;
        bit seen;
        accept_sample(16'h4000, 1'b0, 0, 16'h0);
        repeat (31) @(negedge clk);
        n_checks++;
        if (alu_en_mac !== 1'b1 || alu_a_q15 !== 16'h0 || alu_b_q15 !== 16'h4000) begin
            n_fail++;
            $display("FAIL tap30: en=%b a=%h b=%h expected 1 0000 4000", alu_en_mac, alu_a_q15, alu_b_q15);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || alu_en_mac !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: ready=%b valid=%b en=%b expected 1 0 0", s_ready, m_valid, alu_en_mac);
        end
        seen = 1'b0;
        guard = 0;
        while (guard < NT + 8) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen = 1'b1;
            guard++;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL midreset_no_output: m_valid seen 1 expected 0");
        end
        test_impulse();
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic s;
        bit we;
        load_coefs(16'h0, 1'b1);
        for (int n = 0; n < 30; n++) begin
            we = ($urandom_range(0, 3) == 0);
            accept_sample(16'($urandom), we, int'($urandom_range(0, NT - 1)), 16'($urandom));
            finish_result(int'($urandom_range(0, 3)), d, s);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_saturation();
        test_backpressure();
        test_busy_write();
        test_midpass_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fir_mac_seq
`default_nettype wire

// File: doc/fir_mac_seq.md
# fir_mac_seq

Sequencer and sample front-end that drives the `fir_alu` MAC datapath.
- Accepts Q1.15 input samples on a valid/ready stream and stores them in a circular delay line.
- For each accepted sample, runs one accumulator clear followed by NTAPS multiply-accumulate cycles against a coefficient register file.
- Captures the ALU's rounded, saturated Q7.9 result and presents it on an output valid/ready stream.
- Sits between the sample source and `fir_alu`; it is the initiator for the ALU's `clr_acc`/`en_mac`/operand interface.

## Interface
Parameters:
- NTAPS, 64, number of taps; power of two, at least 4.
- AW, $clog2(NTAPS), width of the tap and coefficient address.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  16  input sample, signed Q1.15.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index k.
- coef_wdata  in  16  coefficient h[k], signed Q1.15.
- coef_err  out  1  one-cycle pulse: a write was dropped.
- alu_clr_acc  out  1  to `fir_alu` clr_acc.
- alu_en_mac  out  1  to `fir_alu` en_mac.
- alu_a_q15  out  16  sample operand.
- alu_b_q15  out  16  coefficient operand.
- alu_y_q7_9  in  16  ALU rounded/saturated output.
- alu_y_saturated  in  1  ALU saturation flag.
- m_valid  out  1  output result valid.
- m_ready  in  1  downstream accepts the result.
- m_data  out  16  filter output, signed Q7.9.
- m_sat  out  1  m_data was saturated.
- sat_count  out  16  count of saturated outputs (see Configuration).

## Operation
FSM states: IDLE, CLEAR, MAC, CAPTURE, OUT.

- **IDLE**
  - s_ready=1.
  - On s_valid&&s_ready: write s_data to dline[wr_ptr], advance wr_ptr (mod NTAPS), go to CLEAR.
- **CLEAR**
  - alu_clr_acc=1 and alu_en_mac=0 for exactly one cycle.
  - Clear the tap counter k; go to MAC.
- **MAC**
  - alu_en_mac=1 for NTAPS consecutive cycles, k=0..NTAPS-1.
  - alu_a_q15 = dline[(newest_ptr - k) mod NTAPS], where newest_ptr is the slot just written, so k=0 is the current sample.
  - alu_b_q15 = coef[k].
  - After k=NTAPS-1, go to CAPTURE.
- **CAPTURE**
  - alu_en_mac=0.
  - Register m_data<=alu_y_q7_9 and m_sat<=alu_y_saturated; set m_valid=1; go to OUT.
- **OUT**
  - Hold m_valid, m_data and m_sat stable.
  - On m_valid&&m_ready: clear m_valid, go to IDLE.

Driving rules:
- Operands are 0 in every state other than MAC.
- s_ready is 0 in every state other than IDLE; no sample is accepted while a result is pending.

Coefficient writes:
- Writes take effect only in IDLE.
- coef_we in any other state is dropped, coef_err pulses for one cycle, and the coefficient array is unchanged.
- A write and a sample acceptance in the same IDLE cycle are both performed; the new coefficient is used by that sample's MAC pass.

Arithmetic:
- No arithmetic in this block; products, accumulation, rounding and saturation belong to `fir_alu`.
- Wrap-around: the pointer arithmetic is modulo NTAPS via an AW-bit wrap.

## Timing
Latency and throughput:
- Acceptance edge E0; alu_clr_acc is sampled at E1.
- MACs are sampled at E2..E(NTAPS+1).
- Result is registered at E(NTAPS+2), so m_valid is high after E(NTAPS+2): 66 edges for NTAPS=64.
- Minimum sample period with m_ready held high is NTAPS+4 cycles.

Reset values (rst sampled at an edge):
- State=IDLE, wr_ptr=0, k=0.
- Delay line and coefficients all 0.
- s_ready=1 in the cycle after reset.
- m_valid=0, m_data=0, m_sat=0, coef_err=0.
- alu_clr_acc=0, alu_en_mac=0, operands=0, sat_count=0.

Reset mid-operation:
- Abandons the pass; no m_valid is produced.
- The next accepted sample starts from the cleared history.

## Configuration
- FIR_MAC_SEQ_SAT_CNT_EN defined:
  - sat_count increments (saturating at 0xFFFF) on each m_valid&&m_ready handshake with m_sat=1.
  - It is cleared only by rst.
- Not defined: sat_count is tied to 0 and its counter logic is absent.

## Structure
- Package `fir_pkg`:
  - Q15/Q7.9 typedefs.
  - Default NTAPS.
  - The FSM state enum shared with the bench.
- Sub-module `fir_delay_line`:
  - NTAPS x 16 circular register file with write pointer and combinational tap read at (newest - k).
  - Synchronous reset to zero.
- The coefficient array and FSM stay in the top.

## Test plan
1. **Impulse.** All h=0x4000; inputs 0x4000 then 64 zeros.
   - First 64 outputs are 128 (0x0080); 65th is 0; m_sat=0 throughout.
2. **Step.** All h=0x4000; constant input 0x4000.
   - Output n is 128*(n+1) for n<64, then 8192 steady.
3. **Saturation.** All h=0x8000; constant input 0x8000.
   - Output 62 is 32256, m_sat=0.
   - Output 63 is 0x7FFF, m_sat=1.
   - With the macro defined, sat_count increments once per subsequent output.
4. **Backpressure.** m_ready held low for 10 cycles after m_valid.
   - m_data/m_sat stable; s_ready=0; a waiting s_valid is not accepted.
   - Releasing m_ready returns the block to IDLE, and the sample is accepted on the next edge.
5. **Write while busy.** coef_we during MAC.
   - coef_err pulses for one cycle; the coefficient read back in a later pass is unchanged.
6. **Mid-pass reset.** rst asserted at tap 30.
   - Next cycle: s_ready=1, m_valid=0, alu_en_mac=0.
   - Reloading coefficients and rerunning scenario 1 gives identical results.
